mem_port_ctrl: RTL and testbench

- Memory-side responder for the register bank's memory micro-operations.
- Accepts the MC control pair (bit0 MW, bit1 MR) plus a word address and the WRdata word from the working register.
- Runs a 4-phase req/ack handshake with external data memory and returns read words on Mdata, which feeds the register bank's memory-data input.
- Sits between the register bank/microsequencer and the memory.

---
 rtl/mem_port_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: 4-phase req/ack responder for register-bank memory micro-ops.
// Optional handshake timeout when MEM_PORT_TIMEOUT_EN is defined.
module mem_port_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MC,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] WRdata,
  output logic [DATA_W-1:0] Mdata,
  output logic              mdata_valid,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    DONE
  } state_t;

  state_t state;
  logic   rd_op;
  logic   op_wr;
  logic   op_rd;
  logic   op_bad;

  assign op_wr  = (MC == 2'b01);
  assign op_rd  = (MC == 2'b10);
  assign op_bad = (MC == 2'b11);

  if (WAIT_MAX < 1) begin : g_bad_wait
    $error("WAIT_MAX must be at least 1");
  end

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CLAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] wcnt;
  logic          wexp;

  // last waiting cycle before the bound is reached
  assign wexp = (wcnt == CLAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_op       <= 1'b0;
      Mdata       <= '0;
      mdata_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef MEM_PORT_TIMEOUT_EN
      wcnt        <= '0;
`endif
    end else begin
      done        <= 1'b0;
      mdata_valid <= 1'b0;
      err         <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          unique case (1'b1)
            op_wr, op_rd: begin
              mem_addr <= addr;
              if (op_wr) mem_wdata <= WRdata;
              mem_we  <= MC[0];
              rd_op   <= MC[1];
              mem_req <= 1'b1;
              busy    <= 1'b1;
              state   <= REQ;
`ifdef MEM_PORT_TIMEOUT_EN
              wcnt    <= '0;
`endif
            end
            op_bad: err <= 1'b1;
            default: ;
          endcase
        end
        REQ: begin
          if (mem_ack) begin
            if (rd_op) Mdata <= mem_rdata;
            mem_req <= 1'b0;
            state   <= RELEASE;
`ifdef MEM_PORT_TIMEOUT_EN
            wcnt    <= '0;
          end else if (wexp) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wcnt    <= wcnt + 1'b1;
`endif
          end
        end
        RELEASE: begin
          if (!mem_ack) begin
            mem_we <= 1'b0;
            state  <= DONE;
`ifdef MEM_PORT_TIMEOUT_EN
          end else if (wexp) begin
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wcnt    <= wcnt + 1'b1;
`endif
          end
        end
        DONE: begin
          // busy is left high here and drops on the first IDLE cycle
          done        <= 1'b1;
          mdata_valid <= rd_op;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: randomized bench with a transaction-level memory model.
// Timeout checks follow MEM_PORT_TIMEOUT_EN.
module tb_mem_port_ctrl;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int WM = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    MC = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] WRdata = '0;
  logic [DW-1:0] Mdata;
  logic          mdata_valid;
  logic          done;
  logic          busy;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_md = '0;

  int txn_cnt = 0;
  bit mem_en  = 1'b0;
  bit fix     = 1'b0;
  int fix_a   = 0;
  int fix_r   = 0;
  int cur_a   = 0;
  int cur_r   = 0;
  int dly     = -1;

  always #5 clk = ~clk;

  mem_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .MC(MC), .addr(addr), .WRdata(WRdata),
    .Mdata(Mdata), .mdata_valid(mdata_valid), .done(done), .busy(busy),
    .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory responder: ack after cur_a cycles, release cur_r cycles later
  initial begin : responder
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!mem_en) begin
        mem_ack = 1'b0;
        dly     = -1;
      end else if (!mem_ack) begin
        if (!mem_req) dly = -1;
        else begin
          if (dly < 0) begin
            cur_a = fix ? fix_a : int'($urandom_range(0, 3));
            dly   = cur_a;
          end
          if (dly == 0) begin
            mem_ack = 1'b1;
            txn_cnt++;
            if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
            else mem_rdata = mem[mem_addr[7:0]];
            cur_r = fix ? fix_r : int'($urandom_range(0, 2));
            dly   = cur_r;
          end else dly--;
        end
      end else if (!mem_req) begin
        if (dly == 0) begin
          mem_ack   = 1'b0;
          mem_rdata = DW'($urandom);
          dly       = -1;
        end else dly--;
      end
    end
  end

  task automatic do_op(input logic [1:0] mc, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit hold);
    int k;
    int t0;
    int n_done;
    int n_mv;
    int n_err;
    int done_k;
    int req_k;
    bit ok;
    bit rd;
    bit wr;
    rd = (mc == 2'b10);
    wr = (mc == 2'b01);
    t0 = txn_cnt;
    MC = mc;
    addr = a;
    WRdata = d;
    @(posedge clk);
    #1;
    if (!hold || !(rd || wr)) begin
      MC = 2'b00;
      addr = AW'($urandom);
      WRdata = DW'($urandom);
    end
    if (mc == 2'b11) begin
      chk("ill_err", err, 1);
      chk("ill_req", mem_req, 0);
      chk("ill_busy", busy, 0);
      @(posedge clk);
      #1;
      chk("ill_err_clr", err, 0);
      chk("ill_md", Mdata, ref_md);
      return;
    end
    if (mc == 2'b00) begin
      chk("nop_busy", busy, 0);
      chk("nop_req", mem_req, 0);
      return;
    end
    if (wr) ref_mem[a[7:0]] = d;
    if (rd) ref_md = ref_mem[a[7:0]];
    chk("req_rise", mem_req, 1);
    ok = 1'b1;
    n_done = 0;
    n_mv = 0;
    n_err = 0;
    done_k = -1;
    req_k = -1;
    k = 0;
    while (1) begin
      if (mem_req) begin
        req_k = k;
        if (mem_we !== wr || mem_addr !== a || !busy) ok = 1'b0;
        if (wr && mem_wdata !== d) ok = 1'b0;
      end
      if (done) begin
        n_done++;
        done_k = k;
        if (mem_we) ok = 1'b0;
        if (hold) MC = 2'b00;
      end
      if (mdata_valid) begin
        n_mv++;
        if (!done) ok = 1'b0;
      end
      if (err) n_err++;
      if (!busy || k >= 60) break;
      @(posedge clk);
      #1;
      k++;
    end
    chk("op_bound", k < 60, 1);
    chk("req_hold", ok, 1);
    chk("req_fall", req_k, cur_a);
    chk("done_lat", done_k, 3 + cur_a + cur_r);
    chk("busy_fall", k, 4 + cur_a + cur_r);
    chk("done_cnt", n_done, 1);
    chk("mv_cnt", n_mv, rd);
    chk("op_err", n_err, 0);
    chk("mdata", Mdata, ref_md);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("one_txn", txn_cnt - t0, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin : main
    int k;
    int hi;
    int errk;
    int n_dn;
    bit req_at;
    bit busy_at;
    logic [1:0] mc;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_md", Mdata, 0);
    chk("rst_mv", mdata_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    mem_en = 1'b1;
    @(posedge clk);
    #1;

    fix = 1'b1;
    fix_a = 2;
    fix_r = 1;
    do_op(2'b01, 16'h0040, 16'h00F0, 1'b0);
    mem[3] = 16'hBEEF;
    ref_mem[3] = 16'hBEEF;
    fix_a = 0;
    fix_r = 0;
    do_op(2'b10, 16'h0003, 16'h0000, 1'b0);
    do_op(2'b01, 16'h0005, 16'h1234, 1'b0);
    chk("md_after_wr", Mdata, 16'hBEEF);
    fix_a = 1;
    fix_r = 2;
    do_op(2'b10, 16'h0003, 16'h0000, 1'b1);
    do_op(2'b11, 16'h0007, 16'hFFFF, 1'b0);

    // reset while the request is outstanding
    fix_a = 6;
    MC = 2'b10;
    addr = 16'h0005;
    @(posedge clk);
    #1;
    MC = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_req", mem_req, 1);
    rst_n = 1'b0;
    mem_en = 1'b0;
    ref_md = '0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_md", Mdata, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_en = 1'b1;
    fix = 1'b0;
    do_op(2'b10, 16'h0005, 16'h0000, 1'b0);

    // memory that never acknowledges
    mem_en = 1'b0;
    MC = 2'b01;
    addr = 16'h0009;
    WRdata = 16'hA5A5;
    @(posedge clk);
    #1;
    MC = 2'b00;
`ifdef MEM_PORT_TIMEOUT_EN
    errk = -1;
    n_dn = 0;
    req_at = 1'b1;
    busy_at = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (err && errk < 0) begin
        errk = k;
        req_at = mem_req;
        busy_at = busy;
      end
      if (done) n_dn++;
    end
    chk("to_err_k", errk, WM);
    chk("to_req", req_at, 0);
    chk("to_busy", busy_at, 0);
    chk("to_done", n_dn, 0);
    chk("to_md", Mdata, ref_md);
    mem_en = 1'b1;
`else
    hi = 0;
    n_dn = 0;
    for (k = 0; k < 120; k++) begin
      @(posedge clk);
      #1;
      if (mem_req && busy) hi++;
      if (err || done) n_dn++;
    end
    chk("noto_req", hi, 120);
    chk("noto_evt", n_dn, 0);
    rst_n = 1'b0;
    ref_md = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_en = 1'b1;
`endif
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      mc = 2'($urandom);
      do_op(mc, {8'($urandom), 5'd0, 3'($urandom)}, DW'($urandom),
            bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
